// File: rtl/mmio_decoder_pkg.sv
// Shared types and default address map for the MMIO decoder.
// FSM state, access region and map/latency defaults.
package mmio_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_OPORT,
        REG_IPORT,
        REG_NONE
    } region_t;

    localparam int          IDX_W        = 6;
    localparam int          DEF_N_OPORTS = 4;
    localparam int          DEF_N_IPORTS = 4;
    localparam int          DEF_RAM_AW   = 13;
    localparam int          DEF_RAM_LAT  = 1;
    localparam logic [31:0] DEF_IO_BASE  = 32'h0000_2000;

endpackage

// File: rtl/mmio_region_decode.sv
// Combinational address classifier for the MMIO decoder.
// Ports: addr/we in; region, port idx and illegal (IPORT write) out.
import mmio_decoder_pkg::*;

module mmio_region_decode #(
    parameter int          N_OPORTS = DEF_N_OPORTS,
    parameter int          N_IPORTS = DEF_N_IPORTS,
    parameter int          RAM_AW   = DEF_RAM_AW,
    parameter logic [31:0] IO_BASE  = DEF_IO_BASE
) (
    input  logic [31:0]      addr,
    input  logic             we,
    output region_t          region,
    output logic [IDX_W-1:0] idx,
    output logic             illegal
);

    localparam int NP = N_OPORTS + N_IPORTS;

    logic [31:0]      off;
    logic [IDX_W-1:0] word;

    assign off  = addr - IO_BASE;
    assign word = off[7:2];

    always_comb begin
        region  = REG_NONE;
        idx     = '0;
        illegal = 1'b0;
        if (addr[1:0] != 2'b00) begin
            region = REG_NONE;
        end else if ((addr >> RAM_AW) == 32'd0) begin
            region = REG_RAM;
        end else if (addr >= IO_BASE && off < 32'(4 * NP)) begin
            if (word < IDX_W'(N_OPORTS)) begin
                region = REG_OPORT;
                idx    = word;
            end else begin
                region  = REG_IPORT;
                idx     = word - IDX_W'(N_OPORTS);
                illegal = we;
            end
        end
    end

endmodule

// File: rtl/mmio_decoder.sv
// Handshaked MMIO decoder: data RAM, N output ports, N input ports.
// Ports: req/we/addr/wdata -> ready/rdata/fault; RAM and port strobes.
// Optional MMIO_DECODER_FAULT_LOG_EN adds fault_count and fault_addr.
import mmio_decoder_pkg::*;

module mmio_decoder #(
    parameter int          N_OPORTS = DEF_N_OPORTS,
    parameter int          N_IPORTS = DEF_N_IPORTS,
    parameter int          RAM_AW   = DEF_RAM_AW,
    parameter logic [31:0] IO_BASE  = DEF_IO_BASE,
    parameter int          RAM_LAT  = DEF_RAM_LAT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  ready,
    output logic [31:0]           rdata,
    output logic                  fault,
    output logic                  dataram_we,
    output logic [RAM_AW-3:0]     dataram_addr,
    output logic [31:0]           dataram_wdata,
    input  logic [31:0]           dataram_rdata,
    output logic [N_OPORTS-1:0]   oport_we,
    output logic [31:0]           oport_wdata,
    input  logic [32*N_OPORTS-1:0] oport_rdata,
    input  logic [32*N_IPORTS-1:0] iport_rdata
`ifdef MMIO_DECODER_FAULT_LOG_EN
    ,
    output logic [15:0]           fault_count,
    output logic [31:0]           fault_addr
`endif
);

    state_t           state;
    region_t          dec_region;
    logic [IDX_W-1:0] dec_idx;
    logic             dec_illegal;

    logic             acc_we;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    region_t          acc_region;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_fault;
    logic [31:0]      cap;
    logic [2:0]       cnt;

    logic [N_OPORTS-1:0] port_hot;
    logic [31:0]         osel;
    logic [31:0]         isel;

    mmio_region_decode #(
        .N_OPORTS (N_OPORTS),
        .N_IPORTS (N_IPORTS),
        .RAM_AW   (RAM_AW),
        .IO_BASE  (IO_BASE)
    ) u_decode (
        .addr    (addr),
        .we      (we),
        .region  (dec_region),
        .idx     (dec_idx),
        .illegal (dec_illegal)
    );

    always_comb begin
        port_hot = '0;
        osel     = '0;
        isel     = '0;
        for (int k = 0; k < N_OPORTS; k++) begin
            if (acc_idx == IDX_W'(k)) begin
                port_hot[k] = 1'b1;
                osel        = oport_rdata[32*k +: 32];
            end
        end
        for (int k = 0; k < N_IPORTS; k++) begin
            if (acc_idx == IDX_W'(k)) begin
                isel = iport_rdata[32*k +: 32];
            end
        end
    end

`ifndef MMIO_DECODER_FAULT_LOG_EN
    logic unused_ok;
    assign unused_ok = ^{acc_addr[31:RAM_AW], acc_addr[1:0]};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ready         <= 1'b0;
            fault         <= 1'b0;
            rdata         <= '0;
            dataram_we    <= 1'b0;
            dataram_addr  <= '0;
            dataram_wdata <= '0;
            oport_we      <= '0;
            oport_wdata   <= '0;
            acc_we        <= 1'b0;
            acc_addr      <= '0;
            acc_wdata     <= '0;
            acc_region    <= REG_NONE;
            acc_idx       <= '0;
            acc_fault     <= 1'b0;
            cap           <= '0;
            cnt           <= '0;
`ifdef MMIO_DECODER_FAULT_LOG_EN
            fault_count   <= '0;
            fault_addr    <= '0;
`endif
        end else begin
            ready      <= 1'b0;
            fault      <= 1'b0;
            dataram_we <= 1'b0;
            oport_we   <= '0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        acc_we     <= we;
                        acc_addr   <= addr;
                        acc_wdata  <= wdata;
                        acc_region <= dec_region;
                        acc_idx    <= dec_idx;
                        acc_fault  <= (dec_region == REG_NONE)
                                      || dec_illegal;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    dataram_wdata <= acc_wdata;
                    oport_wdata   <= acc_wdata;
                    cap           <= '0;
                    state         <= RESP;
                    if (!acc_fault) begin
                        unique case (acc_region)
                            REG_RAM: begin
                                dataram_addr <= acc_addr[RAM_AW-1:2];
                                if (acc_we) begin
                                    dataram_we <= 1'b1;
                                end else if (RAM_LAT > 0) begin
                                    cnt   <= 3'(RAM_LAT - 1);
                                    state <= WAIT;
                                end
                            end
                            REG_OPORT: begin
                                if (acc_we) oport_we <= port_hot;
                                else        cap      <= osel;
                            end
                            REG_IPORT: cap <= isel;
                            default: ;
                        endcase
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) state <= RESP;
                    else             cnt   <= cnt - 3'd1;
                end
                RESP: begin
                    // RAM data is taken on this edge so the sample
                    // lands exactly RAM_LAT cycles after the address.
                    ready <= 1'b1;
                    fault <= acc_fault;
                    if (acc_we || acc_fault)
                        rdata <= '0;
                    else if (acc_region == REG_RAM)
                        rdata <= dataram_rdata;
                    else
                        rdata <= cap;
`ifdef MMIO_DECODER_FAULT_LOG_EN
                    if (acc_fault) begin
                        fault_addr <= acc_addr;
                        if (fault_count != 16'hFFFF)
                            fault_count <= fault_count + 16'd1;
                    end
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
